ex_mem_flag_stage: RTL and testbench

//  EX->MEM pipeline register sitting directly downstream of the 16-bit ALU.

---
 rtl/wisc_pkg.sv | 22 ++
 rtl/flag_calc.sv | 31 +++
 rtl/ex_mem_flag_stage.sv | 91 +++++++++
 tb/tb_ex_mem_flag_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// wisc_pkg: ALU command encodings and flag bit positions shared by the EX/MEM stage
package wisc_pkg;
  localparam logic [3:0] CMD_ADD = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0100;
  localparam logic [3:0] CMD_NOR = 4'b0101;
  localparam logic [3:0] CMD_SLL = 4'b0110;
  localparam logic [3:0] CMD_SRL = 4'b0111;
  localparam logic [3:0] CMD_SRA = 4'b1000;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;
  // Commands whose result is a true two's-complement sum and so own all three flags.
  function automatic logic is_arith(input logic [3:0] cmd);
    return cmd == CMD_ADD || cmd == CMD_SUB;
  endfunction
  // Logic and shift commands only define the zero flag.
  function automatic logic is_zero_only(input logic [3:0] cmd);
    return cmd == CMD_AND || cmd == CMD_NOR || cmd == CMD_SLL ||
           cmd == CMD_SRL || cmd == CMD_SRA;
  endfunction
endpackage

// File: rtl/flag_calc.sv
// flag_calc: combinational {Z,V,N} generation and per-command flag write mask
module flag_calc
  import wisc_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] result,
  input  logic          a_msb,
  input  logic          b_msb,
  input  logic [3:0]    cmd,
  output logic [2:0]    flags,
  output logic [2:0]    mask
);
  logic bin;
  logic arith;
  logic zonly;
  // Overflow uses the effective b sign, i.e. after the subtract inversion.
  always_comb begin
    bin          = b_msb ^ cmd[1];
    arith        = is_arith(cmd);
    zonly        = is_zero_only(cmd);
    flags        = '0;
    flags[FLAG_Z] = result == '0;
    flags[FLAG_N] = result[DW-1];
    flags[FLAG_V] = (a_msb == bin) && (result[DW-1] != a_msb);
    mask         = '0;
    mask[FLAG_Z] = arith || zonly;
    mask[FLAG_V] = arith;
    mask[FLAG_N] = arith;
  end
endmodule

// File: rtl/ex_mem_flag_stage.sv
// ex_mem_flag_stage: EX->MEM pipeline register with condition flags, flush and stall counter
module ex_mem_flag_stage
  import wisc_pkg::*;
#(
  parameter int DW    = 16,
  parameter int RW    = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [DW-1:0]    alu_result,
  input  logic             alu_a_msb,
  input  logic             alu_b_msb,
  input  logic [3:0]       alu_cmd,
  input  logic [RW-1:0]    ex_dst,
  input  logic             ex_we,
  input  logic             flush,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [DW-1:0]    mem_result,
  output logic [RW-1:0]    mem_dst,
  output logic             mem_we,
  output logic [2:0]       flags,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             clr_cnt
);
  logic             valid_q, valid_d;
  logic [DW-1:0]    result_q;
  logic [RW-1:0]    dst_q;
  logic             we_q;
  logic [2:0]       flags_q, flags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, drain, stall;
  logic [2:0]       new_flags, flag_mask, wmask;

  flag_calc #(.DW(DW)) u_flag_calc (
    .result (alu_result),
    .a_msb  (alu_a_msb),
    .b_msb  (alu_b_msb),
    .cmd    (alu_cmd),
    .flags  (new_flags),
    .mask   (flag_mask)
  );

  // Handshake, flag merge and stall counter next-state; flush dominates everything.
  always_comb begin
    ex_ready = !valid_q || mem_ready;
    accept   = ex_valid && ex_ready && !flush;
    drain    = valid_q && mem_ready;
    stall    = ex_valid && !ex_ready;
    valid_d  = flush ? 1'b0 : accept ? 1'b1 : drain ? 1'b0 : valid_q;
    wmask    = flag_mask & {3{accept}};
    flags_d  = (new_flags & wmask) | (flags_q & ~wmask);
    cnt_d    = clr_cnt ? '0 : (stall && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end

  // Control state: entry valid, committed flags, stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  // Payload loads only on accept so a stalled entry stays bit-stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      dst_q    <= '0;
      we_q     <= 1'b0;
    end else if (accept) begin
      result_q <= alu_result;
      dst_q    <= ex_dst;
      we_q     <= ex_we;
    end
  end

  assign mem_valid  = valid_q;
  assign mem_result = result_q;
  assign mem_dst    = dst_q;
  assign mem_we     = we_q && valid_q;
  assign flags      = flags_q;
  assign stall_cnt  = cnt_q;
endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// tb_ex_mem_flag_stage: scoreboard-driven scenario checks for the EX/MEM flag stage
module tb_ex_mem_flag_stage;
  import wisc_pkg::*;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  dst;
    logic        we;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [15:0] alu_result = '0;
  logic        alu_a_msb = 1'b0;
  logic        alu_b_msb = 1'b0;
  logic [3:0]  alu_cmd = CMD_ADD;
  logic [3:0]  ex_dst = '0;
  logic        ex_we = 1'b0;
  logic        flush = 1'b0;
  logic        mem_valid;
  logic        mem_ready = 1'b1;
  logic [15:0] mem_result;
  logic [3:0]  mem_dst;
  logic        mem_we;
  logic [2:0]  flags;
  logic [15:0] stall_cnt;
  logic        clr_cnt = 1'b0;

  int          n_checks = 0;
  int          n_fail = 0;
  entry_t      sb[$];
  logic        m_valid = 1'b0;
  logic [2:0]  m_flags = '0;
  logic [15:0] m_cnt = '0;

  ex_mem_flag_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_result(alu_result), .alu_a_msb(alu_a_msb), .alu_b_msb(alu_b_msb),
    .alu_cmd(alu_cmd), .ex_dst(ex_dst), .ex_we(ex_we), .flush(flush),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_result(mem_result),
    .mem_dst(mem_dst), .mem_we(mem_we), .flags(flags), .stall_cnt(stall_cnt),
    .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [3:0] cmd, input logic a, input logic b,
                       input logic [15:0] res, input logic [3:0] dst, input logic we);
    ex_valid = v; alu_cmd = cmd; alu_a_msb = a; alu_b_msb = b;
    alu_result = res; ex_dst = dst; ex_we = we;
  endtask

  // Advance one clock, updating the reference model from the inputs currently driven.
  task automatic step();
    logic acc, drn, rdy, z, v, n, bin;
    entry_t e;
    rdy = !m_valid || mem_ready;
    acc = ex_valid && rdy && !flush;
    drn = m_valid && mem_ready;
    bin = alu_b_msb ^ alu_cmd[1];
    z = alu_result == 16'h0;
    n = alu_result[15];
    v = (alu_a_msb == bin) && (alu_result[15] != alu_a_msb);
    e = '{res: alu_result, dst: ex_dst, we: ex_we};
    @(posedge clk);
    if (flush) begin
      m_valid = 1'b0;
      sb.delete();
    end else begin
      if (drn) void'(sb.pop_front());
      if (acc) sb.push_back(e);
      m_valid = acc ? 1'b1 : (drn ? 1'b0 : m_valid);
    end
    if (acc && (alu_cmd == CMD_ADD || alu_cmd == CMD_SUB)) m_flags = {z, v, n};
    else if (acc && (alu_cmd == CMD_AND || alu_cmd == CMD_NOR || alu_cmd == CMD_SLL ||
                     alu_cmd == CMD_SRL || alu_cmd == CMD_SRA)) m_flags[2] = z;
    if (clr_cnt) m_cnt = '0;
    else if (ex_valid && !rdy && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    #1;
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_flags = '0; m_cnt = '0; sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 4'($urandom), 1'($urandom));
      mem_ready = 1'($urandom); flush = 1'($urandom); clr_cnt = 1'($urandom);
      @(posedge clk); #1;
      n_checks++;
      if ({mem_valid, mem_result, mem_dst, mem_we, flags, stall_cnt} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got v=%b r=%h d=%h we=%b f=%b c=%h expected all zero",
                 mem_valid, mem_result, mem_dst, mem_we, flags, stall_cnt);
      end
      n_checks++;
      if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ex_ready: got %b expected 1", ex_ready); end
    end
    drive(0, CMD_ADD, 0, 0, 16'h0, 4'h0, 0);
    mem_ready = 1'b1; flush = 1'b0; clr_cnt = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_overflow_add();
    drive(1, CMD_ADD, 0, 0, 16'h8000, 4'h3, 1);
    mem_ready = 1'b1;
    step();
    n_checks++;
    if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b expected 1", mem_valid); end
    n_checks++;
    if (mem_result !== 16'h8000 || sb.size() != 1 || mem_result !== sb[0].res)
      begin n_fail++; $display("FAIL add_result: got %h expected 8000", mem_result); end
    n_checks++;
    if (mem_dst !== 4'h3 || mem_we !== 1'b1)
      begin n_fail++; $display("FAIL add_dst_we: got %h/%b expected 3/1", mem_dst, mem_we); end
    n_checks++;
    if (flags !== 3'b011) begin n_fail++; $display("FAIL add_flags: got %b expected 011", flags); end
    drive(0, CMD_ADD, 0, 0, 16'h0, 4'h0, 0);
    step();
    n_checks++;
    if (mem_valid !== m_valid || mem_we !== 1'b0)
      begin n_fail++; $display("FAIL add_drain: got v=%b we=%b expected v=%b we=0", mem_valid, mem_we, m_valid); end
  endtask

  task automatic test_zero_sub();
    drive(1, CMD_SUB, 1, 1, 16'h0000, 4'h5, 1);
    step();
    n_checks++;
    if (flags !== 3'b100 || flags !== m_flags)
      begin n_fail++; $display("FAIL sub_flags: got %b expected 100", flags); end
    drive(1, CMD_AND, 1, 0, 16'h0001, 4'h6, 1);
    step();
    n_checks++;
    if (flags !== 3'b000 || flags !== m_flags)
      begin n_fail++; $display("FAIL and_flags: got %b expected 000", flags); end
    n_checks++;
    if (sb.size() != 1 || mem_result !== sb[0].res || mem_dst !== sb[0].dst)
      begin n_fail++; $display("FAIL and_result: got %h/%h expected 0001/6", mem_result, mem_dst); end
    drive(1, CMD_ADD, 0, 1, 16'h7FFF, 4'h2, 0);
    step();
    n_checks++;
    if (flags !== m_flags || mem_result !== 16'h7FFF)
      begin n_fail++; $display("FAIL b2b_add: got f=%b r=%h expected f=%b r=7fff", flags, mem_result, m_flags); end
    drive(0, CMD_ADD, 0, 0, 16'h0, 4'h0, 0);
    step();
  endtask

  task automatic test_backpressure();
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    mem_ready = 1'b0;
    drive(1, CMD_ADD, 0, 0, 16'h1234, 4'h7, 1);
    step();
    drive(1, CMD_SUB, 0, 0, 16'hFFFF, 4'h8, 1);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, ex_ready); end
      step();
      n_checks++;
      if (mem_result !== 16'h1234 || mem_valid !== 1'b1 || flags !== 3'b000)
        begin n_fail++; $display("FAIL bp_hold[%0d]: got r=%h v=%b f=%b expected 1234/1/000", i, mem_result, mem_valid, flags); end
    end
    n_checks++;
    if (stall_cnt !== 16'd3 || stall_cnt !== m_cnt)
      begin n_fail++; $display("FAIL bp_stall_cnt: got %0d expected 3", stall_cnt); end
    mem_ready = 1'b1;
    step();
    n_checks++;
    if (sb.size() != 1 || mem_result !== sb[0].res || mem_dst !== 4'h8)
      begin n_fail++; $display("FAIL bp_next_entry: got %h/%h expected ffff/8", mem_result, mem_dst); end
    n_checks++;
    if (flags !== 3'b001) begin n_fail++; $display("FAIL bp_flags: got %b expected 001", flags); end
    drive(0, CMD_ADD, 0, 0, 16'h0, 4'h0, 0);
    step();
    n_checks++;
    if (flags !== 3'b001 || stall_cnt !== 16'd3 || mem_valid !== 1'b0)
      begin n_fail++; $display("FAIL bp_after: got f=%b c=%0d v=%b expected 001/3/0", flags, stall_cnt, mem_valid); end
  endtask

  task automatic test_flush();
    mem_ready = 1'b0;
    drive(1, CMD_AND, 0, 0, 16'h0005, 4'h9, 1);
    step();
    drive(1, CMD_ADD, 0, 0, 16'h0000, 4'hA, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_checks++;
    if (mem_valid !== 1'b0 || mem_we !== 1'b0)
      begin n_fail++; $display("FAIL flush_valid: got v=%b we=%b expected 0/0", mem_valid, mem_we); end
    n_checks++;
    if (flags !== 3'b001 || flags !== m_flags)
      begin n_fail++; $display("FAIL flush_flags: got %b expected 001", flags); end
    mem_ready = 1'b1;
    drive(0, CMD_ADD, 0, 0, 16'h0, 4'h0, 0);
    step();
  endtask

  task automatic test_reset_mid();
    mem_ready = 1'b0;
    drive(1, CMD_SUB, 1, 0, 16'h4000, 4'hB, 1);
    step();
    step();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({mem_valid, mem_result, mem_dst, mem_we, flags, stall_cnt} !== '0)
      begin n_fail++; $display("FAIL reset_mid: got v=%b r=%h f=%b c=%h expected zeros", mem_valid, mem_result, flags, stall_cnt); end
    drive(0, CMD_ADD, 0, 0, 16'h0, 4'h0, 0);
    mem_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    mem_ready = 1'b0;
    drive(1, CMD_ADD, 0, 0, 16'h0042, 4'h1, 1);
    step();
    for (int i = 0; i < 65541; i++) step();
    n_checks++;
    if (stall_cnt !== 16'hFFFF || stall_cnt !== m_cnt)
      begin n_fail++; $display("FAIL sat_cnt: got %h expected ffff", stall_cnt); end
    n_checks++;
    if (mem_result !== 16'h0042 || mem_valid !== 1'b1)
      begin n_fail++; $display("FAIL sat_hold: got %h/%b expected 0042/1", mem_result, mem_valid); end
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    n_checks++;
    if (stall_cnt !== 16'h0000) begin n_fail++; $display("FAIL clr_cnt: got %h expected 0000", stall_cnt); end
    step();
    n_checks++;
    if (stall_cnt !== 16'h0001 || stall_cnt !== m_cnt)
      begin n_fail++; $display("FAIL cnt_restart: got %h expected 0001", stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_overflow_add();
    test_zero_sub();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
